// File: rtl/rom_region_loader_if.sv
// rtl/rom_region_loader_if.sv - download stream in, region write strobes and load status out
interface rom_region_loader_if #(
    parameter int NUM_REGIONS = 11,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 8,
    parameter int LOCAL_W     = 13
);
    logic                   dl_active;
    logic                   dl_wr;
    logic [ADDR_W-1:0]      dl_addr;
    logic [DATA_W-1:0]      dl_data;

    logic [NUM_REGIONS-1:0] wr_en;
    logic [LOCAL_W-1:0]     wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [NUM_REGIONS-1:0] region_filled;
    logic                   load_busy;
    logic                   load_done;
    logic [2:0]             load_err;
    logic [15:0]            checksum;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  wr_en, wr_addr, wr_data, region_filled,
        input  load_busy, load_done, load_err, checksum
    );

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output wr_en, wr_addr, wr_data, region_filled,
        output load_busy, load_done, load_err, checksum
    );
endinterface

// File: rtl/rom_region_loader.sv
// rtl/rom_region_loader.sv - routes ioctl download bytes to per-region ROM RAMs and supervises the load
module rom_region_loader #(
    parameter int NUM_REGIONS = 11,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END = {
        25'h0D240, 25'h0D220, 25'h0D200, 25'h0D100, 25'h0D000, 25'h0C000,
        25'h0A000, 25'h08000, 25'h06000, 25'h04000, 25'h02000
    },
    parameter int LOCAL_W     = 13
) (
    input logic CLK,
    input logic RESET,
    rom_region_loader_if.slave bus
);
    localparam int CW = LOCAL_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Byte count of region i; region i starts where region i-1 ends.
    function automatic logic [CW-1:0] region_size(input int i);
        logic [ADDR_W-1:0] lo;
        lo = '0;
        for (int k = 0; k < i; k++) begin
            lo = REGION_END[k*ADDR_W +: ADDR_W];
        end
        return CW'(REGION_END[i*ADDR_W +: ADDR_W] - lo);
    endfunction

    state_t                 state;
    logic                   active_q;
    logic [ADDR_W-1:0]      expected;
    logic [CW-1:0]          cnt [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] wr_en_q;
    logic [LOCAL_W-1:0]     wr_addr_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic [NUM_REGIONS-1:0] filled_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2:0]             err_q;
    logic [15:0]            sum_q;

    logic                   rise;
    logic                   fall;
    logic [NUM_REGIONS-1:0] hit;
    logic [ADDR_W-1:0]      base_sel;
    logic [ADDR_W-1:0]      prev_end;
    logic                   found;

    assign rise = bus.dl_active & ~active_q;
    assign fall = ~bus.dl_active & active_q;

    // Priority chain: the lowest region whose end lies above the address wins.
    always_comb begin
        hit      = '0;
        base_sel = '0;
        prev_end = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!found && (bus.dl_addr < REGION_END[i*ADDR_W +: ADDR_W])) begin
                found    = 1'b1;
                hit[i]   = 1'b1;
                base_sel = prev_end;
            end
            prev_end = REGION_END[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            active_q  <= 1'b0;
            expected  <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            filled_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 3'b000;
            sum_q     <= 16'h0000;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            active_q <= bus.dl_active;
            wr_en_q  <= '0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (rise) begin
                        state    <= LOAD;
                        busy_q   <= 1'b1;
                        filled_q <= '0;
                        err_q    <= 3'b000;
                        done_q   <= 1'b0;
                        sum_q    <= 16'h0000;
                        expected <= '0;
                        for (int i = 0; i < NUM_REGIONS; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (bus.dl_wr) begin
                        // Out-of-order writes are still forwarded; the check resyncs on them.
                        if (bus.dl_addr != expected) begin
                            err_q[2] <= 1'b1;
                        end
                        expected <= bus.dl_addr + ADDR_W'(1);
                        if (found) begin
                            wr_en_q   <= hit;
                            wr_addr_q <= LOCAL_W'(bus.dl_addr - base_sel);
                            wr_data_q <= bus.dl_data;
                            sum_q     <= sum_q + 16'(bus.dl_data);
                            for (int i = 0; i < NUM_REGIONS; i++) begin
                                if (hit[i] && (cnt[i] != region_size(i))) begin
                                    cnt[i] <= cnt[i] + CW'(1);
                                    if ((cnt[i] + CW'(1)) == region_size(i)) begin
                                        filled_q[i] <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            err_q[1] <= 1'b1;
                        end
                    end
                    if (fall) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    if (!(&filled_q)) begin
                        err_q[0] <= 1'b1;
                    end
                    if ((&filled_q) && (err_q == 3'b000)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= ERR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.region_filled = filled_q;
    assign bus.load_busy     = busy_q;
    assign bus.load_done     = done_q;
    assign bus.load_err      = err_q;
    assign bus.checksum      = sum_q;
endmodule
